// File: rtl/bp_be_late_wb_arbiter.sv
// Late-writeback arbiter: one-entry buffer per long-latency producer, round-robin onto the scheduler's late_wb slot.
// Optional statistics port is enabled with the BP_BE_LATE_WB_STATS_EN macro.
module bp_be_late_wb_arbiter #(
  parameter int num_req_p      = 3,
  parameter int wb_pkt_width_p = 128,
  parameter int starve_limit_p = 16
) (
  input  logic                                clk_i,
  input  logic                                reset_n_i,
  input  logic [num_req_p-1:0]                req_v_i,
  input  logic [num_req_p*wb_pkt_width_p-1:0] req_pkt_i,
  output logic [num_req_p-1:0]                req_ready_and_o,
  output logic                                late_wb_v_o,
  output logic [wb_pkt_width_p-1:0]           late_wb_pkt_o,
  output logic                                late_wb_force_o,
  input  logic                                late_wb_yumi_i,
  output logic                                busy_o
`ifdef BP_BE_LATE_WB_STATS_EN
  ,
  output logic [3*32-1:0]                     stats_o
`endif
);

  localparam int idx_w = $clog2(num_req_p);

  typedef enum logic {e_idle, e_present} state_e;

  state_e                    state_reg;
  logic [idx_w-1:0]          grant_reg;
  logic [idx_w-1:0]          rr_reg;
  logic [idx_w-1:0]          rr_next;
  logic [7:0]                starve_reg;
  logic [7:0]                starve_inc;
  logic                      force_reg;
  logic                      ready_en_reg;
  logic [num_req_p-1:0]      full_reg;
  logic [num_req_p-1:0]      full_next;
  logic [num_req_p-1:0]      enq;
  logic [num_req_p-1:0]      release_vec;
  logic [wb_pkt_width_p-1:0] buf_reg [num_req_p];
  logic                      yumi_fire;
  logic                      pick_found;
  logic [idx_w-1:0]          pick_idx;

  // Yumi only counts while something is actually presented.
  assign yumi_fire = late_wb_yumi_i & (state_reg == e_present);

  for (genvar gi = 0; gi < num_req_p; gi++) begin : g_req
    assign release_vec[gi]     = yumi_fire & (grant_reg == idx_w'(gi));
    assign req_ready_and_o[gi] = ready_en_reg & (~full_reg[gi] | release_vec[gi]);
    assign enq[gi]             = req_v_i[gi] & req_ready_and_o[gi];
    assign full_next[gi]       = enq[gi] | (full_reg[gi] & ~release_vec[gi]);
  end

  always_ff @(posedge clk_i) begin
    for (int i = 0; i < num_req_p; i++) begin
      if (enq[i]) begin
        buf_reg[i] <= req_pkt_i[i*wb_pkt_width_p +: wb_pkt_width_p];
      end
    end
  end

  assign rr_next = !yumi_fire ? rr_reg
                 : (grant_reg == idx_w'(num_req_p - 1)) ? '0
                 : grant_reg + 1'b1;

  // Search the post-edge occupancy so same-cycle enqueues and refills are visible without a bubble.
  always_comb begin
    int cand;
    cand       = 0;
    pick_found = 1'b0;
    pick_idx   = '0;
    for (int k = 0; k < num_req_p; k++) begin
      cand = int'(rr_next) + k;
      if (cand >= num_req_p) begin
        cand = cand - num_req_p;
      end
      if (!pick_found && full_next[cand[idx_w-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[idx_w-1:0];
      end
    end
  end

  assign starve_inc = (starve_reg < 8'(starve_limit_p)) ? starve_reg + 8'd1 : starve_reg;

  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      state_reg    <= e_idle;
      grant_reg    <= '0;
      rr_reg       <= '0;
      starve_reg   <= '0;
      force_reg    <= 1'b0;
      full_reg     <= '0;
      ready_en_reg <= 1'b0;
    end else begin
      full_reg     <= full_next;
      ready_en_reg <= 1'b1;
      rr_reg       <= rr_next;
      case (state_reg)
        e_idle: begin
          starve_reg <= '0;
          force_reg  <= 1'b0;
          if (pick_found) begin
            state_reg <= e_present;
            grant_reg <= pick_idx;
          end
        end
        e_present: begin
          if (yumi_fire) begin
            starve_reg <= '0;
            force_reg  <= 1'b0;
            if (pick_found) begin
              grant_reg <= pick_idx;
            end else begin
              state_reg <= e_idle;
            end
          end else begin
            starve_reg <= starve_inc;
            force_reg  <= (starve_inc == 8'(starve_limit_p));
          end
        end
        default: state_reg <= e_idle;
      endcase
    end
  end

  assign late_wb_v_o     = (state_reg == e_present);
  assign late_wb_pkt_o   = buf_reg[grant_reg];
  assign late_wb_force_o = force_reg;
  assign busy_o          = |full_reg;

`ifdef BP_BE_LATE_WB_STATS_EN
  logic [31:0] grants_reg;
  logic [31:0] force_cyc_reg;
  logic [31:0] starve_max_reg;
  logic [31:0] wait_reg;

  // wait_reg is an unclamped copy of the starvation count so the worst wait is recorded past the force limit.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      grants_reg     <= '0;
      force_cyc_reg  <= '0;
      starve_max_reg <= '0;
      wait_reg       <= '0;
    end else begin
      if (yumi_fire) begin
        if (grants_reg != '1) begin
          grants_reg <= grants_reg + 32'd1;
        end
        if (wait_reg > starve_max_reg) begin
          starve_max_reg <= wait_reg;
        end
        wait_reg <= '0;
      end else if (state_reg == e_present) begin
        if (wait_reg != '1) begin
          wait_reg <= wait_reg + 32'd1;
        end
      end else begin
        wait_reg <= '0;
      end
      if (force_reg && (force_cyc_reg != '1)) begin
        force_cyc_reg <= force_cyc_reg + 32'd1;
      end
    end
  end

  assign stats_o = {grants_reg, force_cyc_reg, starve_max_reg};
`endif

`ifndef SYNTHESIS
  logic                      hold_reg;
  logic [wb_pkt_width_p-1:0] pkt_prev_reg;

  always_ff @(posedge clk_i) begin
    hold_reg     <= reset_n_i & late_wb_v_o & ~late_wb_yumi_i;
    pkt_prev_reg <= late_wb_pkt_o;
    if (reset_n_i) begin
      assert (!late_wb_yumi_i || late_wb_v_o);
      assert (!hold_reg || (late_wb_pkt_o == pkt_prev_reg));
      assert ((enq & full_reg & ~release_vec) == '0);
    end
  end
`endif

endmodule

// File: tb/tb_bp_be_late_wb_arbiter.sv
// Bench for bp_be_late_wb_arbiter: per-cycle vector table plus hand-written starvation, reset and stats sequences.
module tb_bp_be_late_wb_arbiter;
  localparam int N  = 3;
  localparam int W  = 128;
  localparam int L  = 16;
  localparam int NV = 15;

  logic           clk_i;
  logic           reset_n_i;
  logic [N-1:0]   req_v_i;
  logic [N*W-1:0] req_pkt_i;
  logic [N-1:0]   req_ready_and_o;
  logic           late_wb_v_o;
  logic [W-1:0]   late_wb_pkt_o;
  logic           late_wb_force_o;
  logic           late_wb_yumi_i;
  logic           busy_o;
`ifdef BP_BE_LATE_WB_STATS_EN
  logic [95:0]    stats_o;
`endif

  bp_be_late_wb_arbiter #(
    .num_req_p(N), .wb_pkt_width_p(W), .starve_limit_p(L)
  ) dut (
    .clk_i(clk_i),
    .reset_n_i(reset_n_i),
    .req_v_i(req_v_i),
    .req_pkt_i(req_pkt_i),
    .req_ready_and_o(req_ready_and_o),
    .late_wb_v_o(late_wb_v_o),
    .late_wb_pkt_o(late_wb_pkt_o),
    .late_wb_force_o(late_wb_force_o),
    .late_wb_yumi_i(late_wb_yumi_i),
    .busy_o(busy_o)
`ifdef BP_BE_LATE_WB_STATS_EN
    ,
    .stats_o(stats_o)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [N-1:0] req_v;
    logic [7:0]   tag;
    logic         yumi;
    logic         exp_v;
    int           exp_g;
    logic [N-1:0] exp_ready;
    logic         exp_busy;
  } vec_t;

  typedef struct packed {
    logic [1:0]   idx;
    logic [W-1:0] pkt;
  } sb_t;

  vec_t tv [NV];
  sb_t  sbq [$];
  int   checks = 0;
  int   errors = 0;

  function automatic logic [W-1:0] mk(input logic [7:0] tag, input int i);
    mk = {112'h0, i[7:0], tag};
  endfunction

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic [N-1:0] v, input logic [7:0] tag, input logic y);
    req_v_i        = v;
    late_wb_yumi_i = y;
    for (int i = 0; i < N; i++) req_pkt_i[i*W +: W] = mk(tag, i);
  endtask

  task automatic sb_push(input int i, input logic [W-1:0] p);
    sb_t e;
    e.idx = i[1:0];
    e.pkt = p;
    sbq.push_back(e);
  endtask

  task automatic sb_pop(input int i, output logic [W-1:0] p);
    bit found;
    found = 0;
    p     = '0;
    for (int j = 0; j < sbq.size(); j++) begin
      if (!found && int'(sbq[j].idx) == i) begin
        p     = sbq[j].pkt;
        found = 1;
        sbq.delete(j);
        break;
      end
    end
    if (!found) begin
      checks++;
      errors++;
      $display("FAIL sb_pop: no expected packet for requester %0d, got %0d entries", i, sbq.size());
    end
  endtask

  logic [W-1:0] exp_pkt;

  initial begin
    // {req_v, tag, yumi, exp_v, exp_grant, exp_ready, exp_busy}
    tv[0]  = '{3'b111, 8'h10, 1'b0, 1'b0, 0, 3'b111, 1'b0};
    tv[1]  = '{3'b000, 8'h00, 1'b1, 1'b1, 0, 3'b001, 1'b1};
    tv[2]  = '{3'b000, 8'h00, 1'b1, 1'b1, 1, 3'b011, 1'b1};
    tv[3]  = '{3'b000, 8'h00, 1'b1, 1'b1, 2, 3'b111, 1'b1};
    tv[4]  = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 3'b111, 1'b0};
    tv[5]  = '{3'b001, 8'hA5, 1'b0, 1'b0, 0, 3'b111, 1'b0};
    tv[6]  = '{3'b000, 8'h00, 1'b1, 1'b1, 0, 3'b111, 1'b1};
    tv[7]  = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 3'b111, 1'b0};
    tv[8]  = '{3'b101, 8'h20, 1'b0, 1'b0, 0, 3'b111, 1'b0};
    tv[9]  = '{3'b101, 8'h21, 1'b1, 1'b1, 2, 3'b110, 1'b1};
    tv[10] = '{3'b101, 8'h22, 1'b1, 1'b1, 0, 3'b011, 1'b1};
    tv[11] = '{3'b101, 8'h23, 1'b1, 1'b1, 2, 3'b110, 1'b1};
    tv[12] = '{3'b000, 8'h00, 1'b1, 1'b1, 0, 3'b011, 1'b1};
    tv[13] = '{3'b000, 8'h00, 1'b1, 1'b1, 2, 3'b111, 1'b1};
    tv[14] = '{3'b000, 8'h00, 1'b0, 1'b0, 0, 3'b111, 1'b0};

    reset_n_i = 1'b0;
    drive('0, 8'h00, 1'b0);
    tick();
    tick();
    chk("reset_v", W'(late_wb_v_o), W'(1'b0));
    chk("reset_force", W'(late_wb_force_o), W'(1'b0));
    chk("reset_busy", W'(busy_o), W'(1'b0));
    chk("reset_ready", W'(req_ready_and_o), W'(3'b000));
    reset_n_i = 1'b1;
    tick();

    for (int n = 0; n < NV; n++) begin
      drive(tv[n].req_v, tv[n].tag, tv[n].yumi);
      #1;
      chk($sformatf("row%0d_v", n), W'(late_wb_v_o), W'(tv[n].exp_v));
      chk($sformatf("row%0d_ready", n), W'(req_ready_and_o), W'(tv[n].exp_ready));
      chk($sformatf("row%0d_busy", n), W'(busy_o), W'(tv[n].exp_busy));
      chk($sformatf("row%0d_force", n), W'(late_wb_force_o), W'(1'b0));
      if (tv[n].exp_v) begin
        sb_pop(tv[n].exp_g, exp_pkt);
        chk($sformatf("row%0d_pkt", n), late_wb_pkt_o, exp_pkt);
        $display("row %0d: grant req %0d pkt %0h", n, tv[n].exp_g, late_wb_pkt_o);
      end
      for (int i = 0; i < N; i++) begin
        if (tv[n].req_v[i] && tv[n].exp_ready[i]) sb_push(i, mk(tv[n].tag, i));
      end
      tick();
    end

    // Starvation: one packet held without yumi, force on the 17th valid cycle until yumi on the 20th.
    drive(3'b010, 8'h30, 1'b0);
    #1;
    chk("starve_enq_v", W'(late_wb_v_o), W'(1'b0));
    sb_push(1, mk(8'h30, 1));
    tick();
    drive('0, 8'h00, 1'b0);
    sb_pop(1, exp_pkt);
    for (int k = 1; k <= 20; k++) begin
      late_wb_yumi_i = (k == 20);
      #1;
      chk($sformatf("starve%0d_v", k), W'(late_wb_v_o), W'(1'b1));
      chk($sformatf("starve%0d_force", k), W'(late_wb_force_o), W'(k >= L + 1));
      chk($sformatf("starve%0d_pkt", k), late_wb_pkt_o, exp_pkt);
      tick();
    end
    $display("starvation: grant req 1 pkt %0h after 20 valid cycles", exp_pkt);
    late_wb_yumi_i = 1'b0;
    #1;
    chk("starve_after_v", W'(late_wb_v_o), W'(1'b0));
    chk("starve_after_force", W'(late_wb_force_o), W'(1'b0));
    chk("starve_after_busy", W'(busy_o), W'(1'b0));
    tick();

    // Reset while presenting with two full buffers; rr pointer must restart at 0.
    drive(3'b011, 8'h40, 1'b0);
    #1;
    sb_push(0, mk(8'h40, 0));
    sb_push(1, mk(8'h40, 1));
    tick();
    drive('0, 8'h00, 1'b0);
    #1;
    chk("midrst_pre_v", W'(late_wb_v_o), W'(1'b1));
    chk("midrst_pre_busy", W'(busy_o), W'(1'b1));
    reset_n_i = 1'b0;
    tick();
    #1;
    chk("midrst_v", W'(late_wb_v_o), W'(1'b0));
    chk("midrst_force", W'(late_wb_force_o), W'(1'b0));
    chk("midrst_busy", W'(busy_o), W'(1'b0));
    chk("midrst_ready", W'(req_ready_and_o), W'(3'b000));
    sbq.delete();
    reset_n_i = 1'b1;
    tick();
    #1;
    chk("postrst_ready", W'(req_ready_and_o), W'(3'b111));
    drive(3'b110, 8'h41, 1'b0);
    #1;
    sb_push(1, mk(8'h41, 1));
    sb_push(2, mk(8'h41, 2));
    tick();
    for (int g = 1; g <= 2; g++) begin
      drive('0, 8'h00, 1'b1);
      #1;
      chk($sformatf("postrst_g%0d_v", g), W'(late_wb_v_o), W'(1'b1));
      sb_pop(g, exp_pkt);
      chk($sformatf("postrst_g%0d_pkt", g), late_wb_pkt_o, exp_pkt);
      $display("post-reset: grant req %0d pkt %0h", g, late_wb_pkt_o);
      tick();
    end
    drive('0, 8'h00, 1'b0);
    #1;
    chk("postrst_idle_v", W'(late_wb_v_o), W'(1'b0));
    chk("postrst_idle_busy", W'(busy_o), W'(1'b0));
    chk("sb_drained", W'(sbq.size()), W'(0));
    tick();

`ifdef BP_BE_LATE_WB_STATS_EN
    // Four immediate grants, then one that waits 18 cycles and is forced for 3.
    reset_n_i = 1'b0;
    tick();
    reset_n_i = 1'b1;
    tick();
    for (int g = 0; g < 4; g++) begin
      drive(3'b001, 8'(g), 1'b0);
      tick();
      drive('0, 8'h00, 1'b1);
      tick();
    end
    drive(3'b001, 8'h55, 1'b0);
    tick();
    drive('0, 8'h00, 1'b0);
    for (int k = 1; k <= 19; k++) begin
      late_wb_yumi_i = (k == 19);
      tick();
    end
    late_wb_yumi_i = 1'b0;
    #1;
    chk("stats_total_grants", W'(stats_o[95:64]), W'(32'd5));
    chk("stats_force_cycles", W'(stats_o[63:32]), W'(32'd3));
    chk("stats_starve_max", W'(stats_o[31:0]), W'(32'd18));
    $display("stats: grants %0d force %0d starve_max %0d", stats_o[95:64], stats_o[63:32], stats_o[31:0]);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
